mesa_uart_tx_sync: RTL and testbench
====================================

# mesa_uart_tx_sync

- Transmit-side UART that drives the serial link into a downstream autobauding receiver.
- Byte source: buffers bytes from a local valid/ready interface in a small FIFO.
- Serialization: 8N1 at a programmable bit period.
- Autobaud sync: prefixes traffic with 0x0A ("\n") so the far end can measure the start bit plus D0 width and confirm lock.
- Placement: between host logic and the `txd` pad.

## Interface
- `FIFO_DEPTH`, default 16. Byte FIFO depth. Must be a power of 2, from 2 to 256.
- `SYNC_CNT`, default 1. Number of 0x0A characters emitted per sync sequence. Range 1 to 15.
- `SYNC_ON_RESET`, default 1. When 1, a sync sequence is pending at reset release.
- `clk`  in  1  Single clock; all logic is on its rising edge.
- `reset_n`  in  1  Asynchronous, active-low reset.
- `baud_div`  in  16  Bit period is `baud_div`+1 clocks. A value of 0 is treated as 1.
- `send_sync`  in  1  One-cycle pulse that requests a sync sequence.
- `tx_byte`  in  8  Write data.
- `tx_valid`  in  1  Write request.
- `tx_ready`  out  1  FIFO not full. A write occurs on `tx_valid & tx_ready`.
- `fifo_level`  out  9  Current FIFO occupancy.
- `txd`  out  1  Serial output; idle level is 1.
- `tx_busy`  out  1  High while a character is being shifted.
- `tx_idle`  out  1  High when the FIFO is empty, no sync is pending and the shifter is idle.

## Operation
- **FSM states:** IDLE, START, DATA, STOP.
- **Bit timer:** a 16-bit down-counter.
  - Loaded with the effective `baud_div` on entry to each bit.
  - A bit ends when the counter reaches 0.
- **`baud_div` sampling:** sampled once per character, on the IDLE->START or STOP->START transition. Changes mid-character have no effect.
- **Character source selection:** evaluated at IDLE, and at the end of STOP.
  - If a sync is pending, the shifter loads 0x0A and decrements the sync counter (initial value `SYNC_CNT`). `sync_pend` clears when the last sync character is loaded.
  - Else, if the FIFO is not empty, it pops one byte and loads it.
  - Else, it returns to IDLE.
- **Character format:**
  - START: `txd`=0 for one bit period.
  - DATA: 8 bits, LSB first, a 3-bit index from 0 to 7.
  - STOP: `txd`=1 for one bit period.
- **Back-to-back characters:** the next START follows STOP immediately, with no extra idle bits.
- **`send_sync`:**
  - Sets `sync_pend` and reloads the sync counter to `SYNC_CNT`.
  - Takes effect at the next character boundary. A character in progress is never truncated.
  - A pulse arriving while sync characters are still being sent restarts the count. A full `SYNC_CNT` sync characters follow the pulse.
- **FIFO:**
  - Circular buffer with pointers one bit wider than the address.
  - Level = write pointer − read pointer, in the width of `fifo_level`.
  - Write at full is ignored: `tx_ready`=0, and data is dropped if `tx_valid` is still asserted.
  - Simultaneous push and pop keeps the level unchanged.
  - There is no same-cycle bypass. A byte written to an empty FIFO is popped no earlier than the next cycle.
- **Reset (`reset_n`=0, at any time, including mid-character):**
  - FIFO is emptied and the FSM goes to IDLE.
  - Outputs: `txd`=1, `tx_ready`=1, `fifo_level`=0, `tx_busy`=0, `tx_idle` = !`SYNC_ON_RESET`.
  - `sync_pend` = `SYNC_ON_RESET`, sync counter = `SYNC_CNT`.
  - A partial character is abandoned; the line returns high at once.

## Timing
- **Registered outputs:** `txd`, `tx_busy`, `tx_idle`, `tx_ready` and `fifo_level` are all registered.
- **Write-to-line latency:** for a byte written at cycle N into an empty FIFO with the FSM in IDLE and no sync pending:
  - Cycle N+1: the FSM pops the byte and enters START.
  - Edge N+2: `txd` falls.
- **Character length:** 10×(`baud_div`+1) clocks. `tx_busy` is high for exactly that span per character.
- **`fifo_level` update:** one cycle after the push or pop edge.
- **`tx_ready` update:** deasserts in the cycle after the write that fills the FIFO.
- **Sync after reset:** with `SYNC_ON_RESET`=1, the first START begins 2 cycles after `reset_n` deasserts, without waiting for any write.
- **`tx_idle`:** rises the cycle after STOP completes with nothing left to send.

## Test plan
- **Reset sync:** `SYNC_ON_RESET`=1, `SYNC_CNT`=1, `baud_div`=3, release reset, no writes -> `txd` = 0,0,1,0,1,0,0,0,0,1 per 4-clock bit (0x0A LSB-first). `tx_busy` high for 40 clocks, then `tx_idle`=1.
- **Single byte latency:** after sync completes, write 0x55 at cycle N -> `txd` falls at edge N+2, then bits 1,0,1,0,1,0,1,0 and stop 1. `fifo_level` goes 0->1->0.
- **Back-to-back:** `baud_div`=0 (treated as 1, 2 clocks/bit); write 0x00, 0xFF, 0xA5 consecutively -> 30 bit periods with no idle gap. Stop bits land at bit positions 9, 19 and 29.
- **Full FIFO:** `FIFO_DEPTH`=4; hold `tx_valid`=1 with 0x11..0x16 while the shifter is busy on 0x11 -> `tx_ready` low at level 4. 0x16 is dropped; the line carries 0x11..0x15 in order.
- **Mid-stream sync:** `SYNC_CNT`=2; pulse `send_sync` during the DATA state of 0x41 with 0x42 queued -> the line carries 0x41, 0x0A, 0x0A, 0x42.
- **Reset mid-character:** assert `reset_n`=0 during DATA bit 3 of 0x3C -> `txd`=1 immediately and `fifo_level`=0. After release, only the sync character is sent.

Source files
------------

// File: rtl/mesa_uart_tx_sync_if.sv
// Byte write channel into the UART transmitter: valid/ready handshake with
// the host as master and the transmitter FIFO as slave.
interface mesa_uart_tx_sync_if;
  logic [7:0] tx_byte;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_byte, output tx_valid, input tx_ready);
  modport slave  (input tx_byte, input tx_valid, output tx_ready);
endinterface

// File: rtl/mesa_uart_tx_sync.sv
// 8N1 UART transmitter with a byte FIFO and an autobaud sync prefix.
// Sync characters (0x0A) are sent ahead of queued data whenever a sync is
// pending, so the far-end receiver can measure start+D0 and lock.
module mesa_uart_tx_sync #(
  parameter int unsigned FIFO_DEPTH    = 16,
  parameter int unsigned SYNC_CNT      = 1,
  parameter bit          SYNC_ON_RESET = 1'b1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [15:0]         baud_div,
  input  logic                send_sync,
  mesa_uart_tx_sync_if.slave  wr,
  output logic [8:0]          fifo_level,
  output logic                txd,
  output logic                tx_busy,
  output logic                tx_idle
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t      state_q;
  logic [15:0] cnt_q, div_q, eff_div;
  logic [2:0]  idx_q;
  logic [7:0]  shift_q, char_d;
  logic        txd_q, tx_busy_q, tx_idle_q, tx_ready_q, arm_q;
  logic        sync_pend_q, sync_pend_d;
  logic [3:0]  sync_left_q, sync_left_d;
  logic [AW:0] wptr_q, wptr_d, rptr_q, rptr_d, used_d;
  logic [8:0]  fifo_level_q, level_d;
  logic [7:0]  mem_q [FIFO_DEPTH];
  logic        push, pop, fifo_empty, at_boundary, load_sync, load_fifo, fsm_idle_d;

  // Character-boundary decisions, FIFO pointer arithmetic and sync bookkeeping.
  always_comb begin
    eff_div     = (baud_div == 16'd0) ? 16'd1 : baud_div;
    push        = wr.tx_valid & tx_ready_q;
    fifo_empty  = (wptr_q == rptr_q);
    // arm_q keeps the shifter quiet for the first cycle after reset release.
    at_boundary = ((state_q == S_IDLE) & arm_q) | ((state_q == S_STOP) & (cnt_q == 16'd0));
    load_sync   = at_boundary & sync_pend_q;
    load_fifo   = at_boundary & ~sync_pend_q & ~fifo_empty;
    pop         = load_fifo;
    char_d      = load_sync ? 8'h0A : mem_q[rptr_q[AW-1:0]];
    wptr_d      = wptr_q + {{AW{1'b0}}, push};
    rptr_d      = rptr_q + {{AW{1'b0}}, pop};
    used_d      = wptr_d - rptr_d;
    level_d     = 9'(used_d);
    sync_left_d = sync_left_q;
    sync_pend_d = sync_pend_q;
    if (send_sync) begin
      // A new request always restarts a full sync sequence.
      sync_left_d = 4'(SYNC_CNT);
      sync_pend_d = 1'b1;
    end else if (load_sync) begin
      sync_left_d = sync_left_q - 4'd1;
      sync_pend_d = (sync_left_q != 4'd1);
    end
    fsm_idle_d = at_boundary ? ~(load_sync | load_fifo) : (state_q == S_IDLE);
  end

  // FIFO storage: write port only, read data is captured by the shifter.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q[AW-1:0]] <= wr.tx_byte;
  end

  // FIFO pointers plus registered occupancy and ready flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q       <= '0;
      rptr_q       <= '0;
      fifo_level_q <= 9'd0;
      tx_ready_q   <= 1'b1;
    end else begin
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      fifo_level_q <= level_d;
      tx_ready_q   <= (level_d != 9'(FIFO_DEPTH));
    end
  end

  // Serializer FSM with bit timer, sync counter and registered line outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= 16'd0;
      div_q       <= 16'd1;
      idx_q       <= 3'd0;
      shift_q     <= 8'h00;
      txd_q       <= 1'b1;
      tx_busy_q   <= 1'b0;
      tx_idle_q   <= !SYNC_ON_RESET;
      arm_q       <= 1'b0;
      sync_pend_q <= SYNC_ON_RESET;
      sync_left_q <= 4'(SYNC_CNT);
    end else begin
      arm_q       <= 1'b1;
      sync_pend_q <= sync_pend_d;
      sync_left_q <= sync_left_d;
      tx_busy_q   <= ~fsm_idle_d;
      tx_idle_q   <= fsm_idle_d & (level_d == 9'd0) & ~sync_pend_d;
      if (load_sync | load_fifo) begin
        // New character: bit period is frozen here for the whole character.
        state_q <= S_START;
        shift_q <= char_d;
        div_q   <= eff_div;
        cnt_q   <= eff_div;
        txd_q   <= 1'b0;
      end else begin
        case (state_q)
          S_START: begin
            if (cnt_q == 16'd0) begin
              state_q <= S_DATA;
              idx_q   <= 3'd0;
              cnt_q   <= div_q;
              txd_q   <= shift_q[0];
            end else begin
              cnt_q <= cnt_q - 16'd1;
            end
          end
          S_DATA: begin
            if (cnt_q == 16'd0) begin
              cnt_q <= div_q;
              if (idx_q == 3'd7) begin
                state_q <= S_STOP;
                txd_q   <= 1'b1;
              end else begin
                idx_q <= idx_q + 3'd1;
                txd_q <= shift_q[idx_q + 3'd1];
              end
            end else begin
              cnt_q <= cnt_q - 16'd1;
            end
          end
          S_STOP: begin
            if (cnt_q == 16'd0) state_q <= S_IDLE;
            else                cnt_q   <= cnt_q - 16'd1;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign wr.tx_ready = tx_ready_q;
  assign fifo_level  = fifo_level_q;
  assign txd         = txd_q;
  assign tx_busy     = tx_busy_q;
  assign tx_idle     = tx_idle_q;

endmodule

// File: tb/tb_mesa_uart_tx_sync.sv
// Directed bench for mesa_uart_tx_sync: the line and status outputs are
// recorded once per cycle and each scenario decodes that trace afterwards.
module tb_mesa_uart_tx_sync;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] baud_div;
  logic        send_sync;
  logic [8:0]  fifo_level;
  logic        txd, tx_busy, tx_idle;

  mesa_uart_tx_sync_if wr_if ();

  mesa_uart_tx_sync #(.FIFO_DEPTH(4), .SYNC_CNT(2), .SYNC_ON_RESET(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .baud_div(baud_div), .send_sync(send_sync),
    .wr(wr_if), .fifo_level(fifo_level), .txd(txd), .tx_busy(tx_busy), .tx_idle(tx_idle)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       txd;
    logic       busy;
    logic       idle;
    logic       ready;
    logic [8:0] level;
  } samp_t;

  samp_t rec[$];
  samp_t now_s;
  bit    rec_en = 1'b0;
  int    total = 0;
  int    bad = 0;

  // One sample per cycle, taken mid-cycle on the falling edge.
  always @(negedge clk) begin
    if (rec_en) begin
      now_s.txd   = txd;
      now_s.busy  = tx_busy;
      now_s.idle  = tx_idle;
      now_s.ready = wr_if.tx_ready;
      now_s.level = fifo_level;
      rec.push_back(now_s);
    end
  end

  // Find the next start bit at or after 'from' and decode one 8N1 frame of p clocks/bit.
  task automatic decode(input int from, input int p, output int s, output logic [7:0] b, output bit good);
    s = -1; b = 8'h00; good = 1'b0;
    for (int i = from; i < rec.size(); i++) begin
      if (rec[i].txd === 1'b0) begin s = i; break; end
    end
    if (s < 0 || s + 10 * p > rec.size()) return;
    good = 1'b1;
    for (int k = 0; k < 10; k++)
      for (int j = 0; j < p; j++)
        if (rec[s + k * p + j].txd !== rec[s + k * p].txd) good = 1'b0;
    if (rec[s].txd !== 1'b0 || rec[s + 9 * p].txd !== 1'b1) good = 1'b0;
    for (int k = 0; k < 8; k++) b[k] = rec[s + (k + 1) * p].txd;
  endtask

  function automatic int count_busy(input int from, input int n);
    int c = 0;
    for (int i = from; i < from + n && i < rec.size(); i++) if (rec[i].busy) c++;
    return c;
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    int s, s2, s3; logic [7:0] b; bit g;
    cycles(3);
    total++;
    if ({txd, wr_if.tx_ready, tx_busy, tx_idle, fifo_level} !== {4'b1100, 9'd0}) begin
      bad++; $display("FAIL reset_outputs got=%b want=%b", {txd, wr_if.tx_ready, tx_busy, tx_idle, fifo_level}, {4'b1100, 9'd0});
    end
    rec.delete(); rec_en = 1'b1; reset_n = 1'b1;
    cycles(100); rec_en = 1'b0;
    decode(0, 4, s, b, g);
    total++; if (s != 2) begin bad++; $display("FAIL reset_sync_start got=%0d want=%0d", s, 2); end
    total++; if (b !== 8'h0A || !g) begin bad++; $display("FAIL reset_sync_char0 got=%h framing=%0d want=0a", b, g); end
    decode(s + 40, 4, s2, b, g);
    total++; if (s2 != s + 40 || b !== 8'h0A || !g) begin bad++; $display("FAIL reset_sync_char1 got=%h at %0d want=0a at %0d", b, s2, s + 40); end
    total++; if (count_busy(0, 100) != 80) begin bad++; $display("FAIL reset_busy_len got=%0d want=80", count_busy(0, 100)); end
    total++; if (rec[s + 79].idle !== 1'b0 || rec[s + 80].idle !== 1'b1 || rec[s + 80].busy !== 1'b0) begin
      bad++; $display("FAIL reset_idle_rise got=%b%b busy=%b want=01 busy=0", rec[s + 79].idle, rec[s + 80].idle, rec[s + 80].busy);
    end
    decode(s + 80, 4, s3, b, g);
    total++; if (s3 != -1) begin bad++; $display("FAIL reset_extra_char got=%0d want=-1", s3); end
    $display("test_reset: sync start=%0d", s);
  endtask

  task automatic test_single_latency;
    int s; logic [7:0] b; bit g;
    rec.delete(); rec_en = 1'b1;
    wr_if.tx_byte = 8'h55; wr_if.tx_valid = 1'b1;
    cycles(1); wr_if.tx_valid = 1'b0;
    cycles(50); rec_en = 1'b0;
    decode(0, 4, s, b, g);
    total++; if (s != 2) begin bad++; $display("FAIL latency_start got=%0d want=%0d", s, 2); end
    total++; if (b !== 8'h55 || !g) begin bad++; $display("FAIL latency_char got=%h framing=%0d want=55", b, g); end
    total++; if ({rec[0].level, rec[1].level, rec[2].level} !== {9'd0, 9'd1, 9'd0}) begin
      bad++; $display("FAIL latency_level got=%0d,%0d,%0d want=0,1,0", rec[0].level, rec[1].level, rec[2].level);
    end
    total++; if (rec[1].idle !== 1'b0 || rec[s + 40].idle !== 1'b1) begin
      bad++; $display("FAIL latency_idle got=%b,%b want=0,1", rec[1].idle, rec[s + 40].idle);
    end
    total++; if (count_busy(0, 52) != 40) begin bad++; $display("FAIL latency_busy_len got=%0d want=40", count_busy(0, 52)); end
    $display("test_single_latency: 0x55 start=%0d", s);
  endtask

  task automatic test_back_to_back;
    int s, sn; logic [7:0] b; bit g;
    logic [7:0] vec [3] = '{8'h00, 8'hFF, 8'hA5};
    baud_div = 16'd0;
    rec.delete(); rec_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wr_if.tx_byte = vec[i]; wr_if.tx_valid = 1'b1; cycles(1);
    end
    wr_if.tx_valid = 1'b0;
    cycles(80); rec_en = 1'b0;
    decode(0, 2, s, b, g);
    total++; if (s != 2) begin bad++; $display("FAIL b2b_start got=%0d want=%0d", s, 2); end
    for (int i = 0; i < 3; i++) begin
      decode(s + 20 * i, 2, sn, b, g);
      total++; if (sn != s + 20 * i || b !== vec[i] || !g) begin
        bad++; $display("FAIL b2b_char%0d got=%h at %0d framing=%0d want=%h at %0d", i, b, sn, g, vec[i], s + 20 * i);
      end
    end
    total++; if (rec[3].level !== 9'd2) begin bad++; $display("FAIL b2b_level got=%0d want=2", rec[3].level); end
    total++; if (count_busy(s, 60) != 60 || rec[s + 60].busy !== 1'b0) begin
      bad++; $display("FAIL b2b_busy got=%0d want=60", count_busy(s, 61));
    end
    $display("test_back_to_back: 3 chars from %0d", s);
  endtask

  task automatic test_full_fifo;
    int s, sn, guard; logic [7:0] b; bit g; logic r;
    baud_div = 16'd3;
    rec.delete(); rec_en = 1'b1;
    wr_if.tx_byte = 8'h11; wr_if.tx_valid = 1'b1; guard = 0;
    while (wr_if.tx_byte != 8'h16 && guard < 20) begin
      @(negedge clk); r = wr_if.tx_ready;
      cycles(1);
      if (r) wr_if.tx_byte = wr_if.tx_byte + 8'd1;
      guard++;
    end
    total++; if (guard != 5) begin bad++; $display("FAIL full_accept_cycles got=%0d want=5", guard); end
    cycles(10); wr_if.tx_valid = 1'b0;
    cycles(220); rec_en = 1'b0;
    total++; if ({rec[4].ready, rec[4].level} !== {1'b1, 9'd3}) begin
      bad++; $display("FAIL full_level3 got=ready %b level %0d want=ready 1 level 3", rec[4].ready, rec[4].level);
    end
    total++; if ({rec[5].ready, rec[5].level, rec[14].ready, rec[14].level} !== {1'b0, 9'd4, 1'b0, 9'd4}) begin
      bad++; $display("FAIL full_ready_low got=%b/%0d %b/%0d want=0/4 0/4", rec[5].ready, rec[5].level, rec[14].ready, rec[14].level);
    end
    decode(0, 4, s, b, g);
    total++; if (s != 2) begin bad++; $display("FAIL full_start got=%0d want=%0d", s, 2); end
    for (int i = 0; i < 5; i++) begin
      decode(s + 40 * i, 4, sn, b, g);
      total++; if (sn != s + 40 * i || b !== 8'h11 + 8'(i) || !g) begin
        bad++; $display("FAIL full_char%0d got=%h at %0d want=%h at %0d", i, b, sn, 8'h11 + 8'(i), s + 40 * i);
      end
    end
    decode(s + 200, 4, sn, b, g);
    total++; if (sn != -1) begin bad++; $display("FAIL full_drop got=%h at %0d want=no char", b, sn); end
    $display("test_full_fifo: 0x11..0x15 from %0d", s);
  endtask

  task automatic test_mid_sync;
    int s, sn; logic [7:0] b; bit g;
    logic [7:0] exp_c [4] = '{8'h41, 8'h0A, 8'h0A, 8'h42};
    rec.delete(); rec_en = 1'b1;
    wr_if.tx_byte = 8'h41; wr_if.tx_valid = 1'b1; cycles(1);
    wr_if.tx_byte = 8'h42; cycles(1);
    wr_if.tx_valid = 1'b0;
    cycles(13); send_sync = 1'b1;
    cycles(1); send_sync = 1'b0;
    cycles(180); rec_en = 1'b0;
    decode(0, 4, s, b, g);
    total++; if (s != 2) begin bad++; $display("FAIL msync_start got=%0d want=%0d", s, 2); end
    for (int i = 0; i < 4; i++) begin
      decode(s + 40 * i, 4, sn, b, g);
      total++; if (sn != s + 40 * i || b !== exp_c[i] || !g) begin
        bad++; $display("FAIL msync_char%0d got=%h at %0d want=%h at %0d", i, b, sn, exp_c[i], s + 40 * i);
      end
    end
    decode(s + 160, 4, sn, b, g);
    total++; if (sn != -1) begin bad++; $display("FAIL msync_extra got=%h at %0d want=no char", b, sn); end
    $display("test_mid_sync: 41 0a 0a 42 from %0d", s);
  endtask

  task automatic test_reset_mid;
    int s, sn; logic [7:0] b; bit g;
    rec.delete(); rec_en = 1'b1;
    wr_if.tx_byte = 8'h3C; wr_if.tx_valid = 1'b1; cycles(1);
    wr_if.tx_byte = 8'h99; cycles(1);
    wr_if.tx_valid = 1'b0;
    cycles(17);
    total++; if ({txd, tx_busy, fifo_level} !== {2'b11, 9'd1}) begin
      bad++; $display("FAIL rmid_pre got=%b want=%b", {txd, tx_busy, fifo_level}, {2'b11, 9'd1});
    end
    reset_n = 1'b0; #1;
    total++; if ({txd, wr_if.tx_ready, tx_busy, tx_idle, fifo_level} !== {4'b1100, 9'd0}) begin
      bad++; $display("FAIL rmid_async got=%b want=%b", {txd, wr_if.tx_ready, tx_busy, tx_idle, fifo_level}, {4'b1100, 9'd0});
    end
    cycles(3);
    rec.delete(); reset_n = 1'b1;
    cycles(120); rec_en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      decode(2 + 40 * i, 4, sn, b, g);
      total++; if (sn != 2 + 40 * i || b !== 8'h0A || !g) begin
        bad++; $display("FAIL rmid_sync%0d got=%h at %0d want=0a at %0d", i, b, sn, 2 + 40 * i);
      end
    end
    decode(82, 4, s, b, g);
    total++; if (s != -1) begin bad++; $display("FAIL rmid_stale got=%h at %0d want=no char", b, s); end
    $display("test_reset_mid: sync only after release");
  endtask

  initial begin
    reset_n = 1'b0; baud_div = 16'd3; send_sync = 1'b0;
    wr_if.tx_byte = 8'h00; wr_if.tx_valid = 1'b0;
    test_reset();
    test_single_latency();
    test_back_to_back();
    test_full_fifo();
    test_mid_sync();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
